// File: rtl/slow_clk_pkg.sv
// Shared definitions for the slow clock generator/meter pair.
package slow_clk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StTrack,
        StStall
    } meter_state_e;

    localparam int unsigned DefaultCntW = 27;
    localparam int unsigned BaseClkHz   = 100_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for a slow asynchronous input plus a delay flop for
// detecting both rising and falling edges.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_s,
    output logic sig_edge
);

    logic sync1_q, sync2_q, sig_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sig_d_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sig_d_q <= sync2_q;
        end
    end

    assign sig_s    = sync2_q;
    assign sig_edge = sync2_q ^ sig_d_q;

endmodule

// File: rtl/slow_clk_meter.sv
// Measures the half-period of a slow square wave in clk cycles and reports lock/stall.
// Define SLOW_CLK_METER_AVG_EN to report a 4-capture running average on half_period.
module slow_clk_meter
    import slow_clk_pkg::*;
#(
    parameter int unsigned CNT_W    = DefaultCntW,
    parameter int unsigned TIMEOUT  = 2**27 - 1,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             resetSW_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CntMax     = '1;
    localparam logic [CNT_W-1:0]  CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TolVal     = CNT_W'(TOL);
    localparam logic [MatchW-1:0] LockVal    = MatchW'(LOCK_CNT);

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  raw_q, raw_d;
    logic [CNT_W-1:0]  hp_q, hp_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              valid_q, valid_d;

    logic             sig_edge;
    logic             sig_s_unused;
    logic             capture;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] diff;
    logic             timed_out;

    sync_edge_det u_sync_edge_det (
        .clk      (clk),
        .rst_n    (resetSW_n),
        .sig_in   (sig_in),
        .sig_s    (sig_s_unused),
        .sig_edge (sig_edge)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        raw_d     = raw_q;
        match_d   = match_q;
        valid_d   = 1'b0;
        capture   = 1'b0;
        cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        diff      = (cnt_q >= raw_q) ? (cnt_q - raw_q) : (raw_q - cnt_q);
        timed_out = (cnt_q >= TimeoutVal);

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (sig_edge) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                end
            end
            StMeasure: begin
                if (sig_edge) begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    raw_d   = cnt_q;
                    cnt_d   = CntOne;
                    match_d = '0;
                    state_d = StTrack;
                end else if (timed_out) begin
                    cnt_d   = '0;
                    match_d = '0;
                    state_d = StStall;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StTrack: begin
                if (sig_edge) begin
                    capture = 1'b1;
                    valid_d = 1'b1;
                    raw_d   = cnt_q;
                    cnt_d   = CntOne;
                    if (diff <= TolVal) begin
                        match_d = (match_q == LockVal) ? match_q : match_q + 1'b1;
                    end else begin
                        match_d = '0;
                    end
                end else if (timed_out) begin
                    cnt_d   = '0;
                    match_d = '0;
                    state_d = StStall;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StStall: begin
                cnt_d   = '0;
                match_d = '0;
                // The interval ending at this edge started before the stall, so discard it.
                if (sig_edge) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                match_d = '0;
            end
        endcase
    end

`ifdef SLOW_CLK_METER_AVG_EN
    logic [CNT_W-1:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
    logic [CNT_W+1:0] sum;
    logic             fill;

    // First capture of a run seeds the whole window so early averages are not skewed.
    always_comb begin
        h0_d = h0_q;
        h1_d = h1_q;
        h2_d = h2_q;
        hp_d = hp_q;
        fill = (state_q == StMeasure);
        if (fill) begin
            sum = {cnt_q, 2'b00};
        end else begin
            sum = {2'b00, cnt_q} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
        end
        if (capture) begin
            hp_d = sum[CNT_W+1:2];
            h0_d = cnt_q;
            h1_d = fill ? cnt_q : h0_q;
            h2_d = fill ? cnt_q : h1_q;
        end
    end

    always_ff @(posedge clk or negedge resetSW_n) begin
        if (!resetSW_n) begin
            h0_q <= '0;
            h1_q <= '0;
            h2_q <= '0;
        end else begin
            h0_q <= h0_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`else
    always_comb begin
        hp_d = capture ? cnt_q : hp_q;
    end
`endif

    always_ff @(posedge clk or negedge resetSW_n) begin
        if (!resetSW_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            raw_q   <= '0;
            hp_q    <= '0;
            match_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            hp_q    <= hp_d;
            match_q <= match_d;
            valid_q <= valid_d;
        end
    end

    assign half_period = hp_q;
    assign meas_valid  = valid_q;
    assign locked      = (match_q == LockVal);
    assign stalled     = (state_q == StStall);

endmodule

// File: tb/tb_slow_clk_meter.sv
// Directed bench for slow_clk_meter: lock, tolerance, stall, async reset, timeout boundary.
module tb_slow_clk_meter;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 128;

    logic             clk;
    logic             resetSW_n;
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             stalled;

    int unsigned n_checks;
    int unsigned n_errors;

    logic [CNT_W-1:0] cap_q[$];
    logic             lock_q[$];

    slow_clk_meter #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .TOL      (2),
        .LOCK_CNT (4)
    ) dut (
        .clk         (clk),
        .resetSW_n   (resetSW_n),
        .sig_in      (sig_in),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .stalled     (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every capture with the lock flag seen alongside it.
    always @(negedge clk) begin
        if (meas_valid) begin
            cap_q.push_back(half_period);
            lock_q.push_back(locked);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        sig_in    = 1'b0;
        resetSW_n = 1'b0;
        repeat (3) @(negedge clk);
        resetSW_n = 1'b1;
        cap_q.delete();
        lock_q.delete();
    endtask

    task automatic tog(input int n);
        repeat (n) @(negedge clk);
        sig_in = ~sig_in;
    endtask

    initial begin
        int n;
        n_checks  = 0;
        n_errors  = 0;
        sig_in    = 1'b0;
        resetSW_n = 1'b0;
        #2;
        check_eq("rst_hp", 32'(half_period), 0);
        check_eq("rst_valid", 32'(meas_valid), 0);
        check_eq("rst_locked", 32'(locked), 0);
        check_eq("rst_stalled", 32'(stalled), 0);

        // Constant input never stalls.
        do_reset();
        repeat (200) @(negedge clk);
        check_eq("idle_stalled", 32'(stalled), 0);
        check_eq("idle_caps", cap_q.size(), 0);
        check_eq("idle_hp", 32'(half_period), 0);

        // Steady half-period 5: lock on the 5th capture.
        do_reset();
        tog(1);
        for (int i = 0; i < 7; i++) tog(5);
        repeat (6) @(negedge clk);
        check_eq("p5_caps", cap_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("p5_hp%0d", i), 32'(cap_q[i]), 5);
            check_eq($sformatf("p5_lock%0d", i), 32'(lock_q[i]), (i >= 4) ? 1 : 0);
        end

        // Alternating 100/103 exceeds tolerance every time.
        do_reset();
        tog(1);
        for (int i = 0; i < 5; i++) tog((i % 2 == 0) ? 100 : 103);
        repeat (6) @(negedge clk);
        check_eq("alt_caps", cap_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("alt_hp%0d", i), 32'(cap_q[i]), (i % 2 == 0) ? 100 : 103);
            check_eq($sformatf("alt_lock%0d", i), 32'(lock_q[i]), 0);
        end

        // Lock, then hold input: stall exactly TIMEOUT cycles after the last reload.
        do_reset();
        tog(1);
        for (int i = 0; i < 4; i++) tog(10);
        repeat (6) @(negedge clk);
        check_eq("stl_pre_lock", 32'(locked), 0);
        tog(4);
        n = 0;
        while (!meas_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("stl_cap_seen", 32'(meas_valid), 1);
        check_eq("stl_locked", 32'(locked), 1);
        n = 0;
        while (!stalled && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("stl_delay", 32'(n), TIMEOUT);
        check_eq("stl_unlock", 32'(locked), 0);
        check_eq("stl_hp_kept", 32'(half_period), 10);
        tog(3);
        repeat (6) @(negedge clk);
        check_eq("stl_clear", 32'(stalled), 0);
        check_eq("stl_nocap", cap_q.size(), 5);
        tog(14);
        repeat (6) @(negedge clk);
        check_eq("stl_recap_n", cap_q.size(), 6);
        check_eq("stl_recap_hp", 32'(cap_q[5]), 20);
        check_eq("stl_recap_lock", 32'(lock_q[5]), 0);

        // Async reset mid-interval discards everything.
        do_reset();
        tog(1);
        for (int i = 0; i < 3; i++) tog(10);
        repeat (5) @(negedge clk);
        check_eq("ar_pre_hp", 32'(half_period), 10);
        @(posedge clk);
        #3;
        resetSW_n = 1'b0;
        #1;
        check_eq("ar_hp", 32'(half_period), 0);
        check_eq("ar_valid", 32'(meas_valid), 0);
        check_eq("ar_locked", 32'(locked), 0);
        check_eq("ar_stalled", 32'(stalled), 0);
        repeat (2) @(negedge clk);
        resetSW_n = 1'b1;
        cap_q.delete();
        lock_q.delete();
        tog(2);
        tog(15);
        repeat (6) @(negedge clk);
        check_eq("ar_caps", cap_q.size(), 1);
        check_eq("ar_cap_hp", 32'(cap_q[0]), 15);

        // Edge coinciding with TIMEOUT captures; one cycle later it stalls instead.
        do_reset();
        tog(1);
        tog(TIMEOUT);
        tog(TIMEOUT);
        repeat (6) @(negedge clk);
        check_eq("to_caps", cap_q.size(), 2);
        check_eq("to_hp0", 32'(cap_q[0]), TIMEOUT);
        check_eq("to_hp1", 32'(cap_q[1]), TIMEOUT);
        check_eq("to_stalled", 32'(stalled), 0);
        tog(TIMEOUT + 1 - 6);
        repeat (6) @(negedge clk);
        check_eq("to_over_caps", cap_q.size(), 2);
        check_eq("to_over_stalled", 32'(stalled), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
